// File: rtl/dht_frame_reader_if.sv
// dht_frame_reader_if
// Control/status bundle between the DHT frame reader and its consumer.
//   start       : one-cycle read request (consumer -> reader)
//   dth_data    : last good 40-bit frame {RH_int, RH_dec, T_int, T_dec, checksum}
//   frame_valid : one-cycle pulse when dth_data is updated
//   busy        : reader is running a transaction
//   err         : 0 none, 1 timeout, 2 checksum; sticky until the next accepted start
// The open-drain sensor line is not carried here; it stays a plain inout on the reader.
// Modports: slave = the reader, master = whoever requests frames.
interface dht_frame_reader_if;
    logic        start;
    logic [39:0] dth_data;
    logic        frame_valid;
    logic        busy;
    logic [1:0]  err;

    modport master (
        output start,
        input  dth_data,
        input  frame_valid,
        input  busy,
        input  err
    );

    modport slave (
        input  start,
        output dth_data,
        output frame_valid,
        output busy,
        output err
    );
endinterface

// File: rtl/dht_frame_reader.sv
// dht_frame_reader
// Single-wire DHT11/DHT22 protocol master. Issues the host start pulse on the
// open-drain line, times the sensor response and the 40 data bits, checks the
// checksum and latches good frames for the downstream indicator stage.
//
// Ports:
//   clk  : system clock, all logic on the rising edge
//   rst  : asynchronous, active-low reset
//   DTH  : open-drain sensor line, driven 0 or released to Z, never driven 1
//   bus  : dht_frame_reader_if.slave (start, dth_data, frame_valid, busy, err)
//
// Optional feature, macro DHT_AUTO_POLL_EN:
//   defined   - an internal start is issued every POLL_MS milliseconds (first one
//               POLL_MS after reset release), ORed with bus.start.
//   undefined - reads happen only on bus.start; no poll counter exists.
module dht_frame_reader #(
    parameter int unsigned CLK_F         = 100000000,
    parameter int unsigned START_LOW_US  = 18000,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned BIT_THRESH_US = 50,
    parameter int unsigned POLL_MS       = 2000
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire               DTH,
    dht_frame_reader_if.slave bus
);

    // Clock cycles per microsecond; clamp so a sub-MHz clock still ticks.
    localparam int unsigned TICK_DIV = (CLK_F / 1000000 > 0) ? (CLK_F / 1000000) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_LOW,
        S_RELEASE,
        S_RESP_LOW,
        S_RESP_HIGH,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_CHECK
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pre;
    logic        r_us_tick;
    logic [31:0] r_us_cnt;

    logic        r_sync1;
    logic        r_sync2;
    logic        r_dth_prev;

    logic [39:0] r_shift;
    logic [5:0]  r_bit_cnt;

    logic [39:0] r_dth_data;
    logic        r_frame_valid;
    logic [1:0]  r_err;

    logic        w_start;
    logic        w_rise;
    logic        w_fall;
    logic        w_timeout;
    logic        w_bit_val;
    logic [7:0]  w_sum;

    logic        w_shift_en;
    logic        w_clr_bits;
    logic        w_latch;
    logic        w_err_tmo;
    logic        w_err_ck;
    logic        w_clr_err;

    // The line is only ever pulled low during the host start pulse. Deriving it
    // straight from the state register means an asynchronous reset releases the
    // line in the same cycle.
    assign DTH = (r_state == S_START_LOW) ? 1'b0 : 1'bz;

`ifdef DHT_AUTO_POLL_EN
    logic [9:0]  r_ms_pre;
    logic [31:0] r_poll_cnt;
    logic        r_poll_start;

    // Millisecond prescaler on top of the µs tick, then a period counter that
    // fires one internal start per POLL_MS. The period restarts on every fire,
    // so a fire that lands while busy is simply lost (start is only sampled in
    // IDLE) and the next attempt is a full period later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ms_pre     <= 10'd0;
            r_poll_cnt   <= 32'd0;
            r_poll_start <= 1'b0;
        end else begin
            r_poll_start <= 1'b0;
            if (r_us_tick) begin
                if (r_ms_pre == 10'd999) begin
                    r_ms_pre <= 10'd0;
                    if (r_poll_cnt >= POLL_MS - 1) begin
                        r_poll_cnt   <= 32'd0;
                        r_poll_start <= 1'b1;
                    end else begin
                        r_poll_cnt <= r_poll_cnt + 32'd1;
                    end
                end else begin
                    r_ms_pre <= r_ms_pre + 10'd1;
                end
            end
        end
    end

    assign w_start = bus.start | r_poll_start;
`else
    // POLL_MS only matters when auto-poll is built in; this sink keeps the
    // parameter referenced in builds without it.
    logic w_unused_poll;
    assign w_unused_poll = ^POLL_MS;

    assign w_start = bus.start;
`endif

    // Free-running microsecond prescaler, independent of the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pre     <= 32'd0;
            r_us_tick <= 1'b0;
        end else begin
            if (r_pre == TICK_DIV - 1) begin
                r_pre     <= 32'd0;
                r_us_tick <= 1'b1;
            end else begin
                r_pre     <= r_pre + 32'd1;
                r_us_tick <= 1'b0;
            end
        end
    end

    // Two-flop synchronizer plus one history flop for edge detection. They
    // reset to 1 (the pulled-up idle level) so no phantom edge appears after
    // reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_dth_prev <= 1'b1;
        end else begin
            r_sync1    <= DTH;
            r_sync2    <= r_sync1;
            r_dth_prev <= r_sync2;
        end
    end

    assign w_rise    =  r_sync2 & ~r_dth_prev;
    assign w_fall    = ~r_sync2 &  r_dth_prev;
    assign w_timeout = (r_us_cnt >= TIMEOUT_US);
    assign w_bit_val = (r_us_cnt > BIT_THRESH_US);
    assign w_sum     = r_shift[39:32] + r_shift[31:24] + r_shift[23:16] + r_shift[15:8];

    // µs counter measures how long the current state (i.e. the current line
    // level) has lasted; it restarts on every state change so the timeout
    // applies per level rather than per frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_us_cnt <= 32'd0;
        end else if ((r_state != w_next_state) || (r_state == S_IDLE)) begin
            r_us_cnt <= 32'd0;
        end else if (r_us_tick) begin
            r_us_cnt <= r_us_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control strobes. Any level that outlasts TIMEOUT_US
    // aborts back to IDLE before an edge in the same cycle is considered.
    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_clr_bits   = 1'b0;
        w_latch      = 1'b0;
        w_err_tmo    = 1'b0;
        w_err_ck     = 1'b0;
        w_clr_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_next_state = S_START_LOW;
                    w_clr_err    = 1'b1;
                end
            end
            S_START_LOW: begin
                if (r_us_cnt >= START_LOW_US) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err_tmo    = 1'b1;
                end else if (w_fall) begin
                    w_next_state = S_RESP_LOW;
                end
            end
            S_RESP_LOW: begin
                if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err_tmo    = 1'b1;
                end else if (w_rise) begin
                    w_next_state = S_RESP_HIGH;
                end
            end
            S_RESP_HIGH: begin
                if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err_tmo    = 1'b1;
                end else if (w_fall) begin
                    w_next_state = S_BIT_LOW;
                    w_clr_bits   = 1'b1;
                end
            end
            S_BIT_LOW: begin
                if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err_tmo    = 1'b1;
                end else if (w_rise) begin
                    w_next_state = S_BIT_HIGH;
                end
            end
            S_BIT_HIGH: begin
                if (w_timeout) begin
                    w_next_state = S_IDLE;
                    w_err_tmo    = 1'b1;
                end else if (w_fall) begin
                    // The falling edge ending bit n is also the start of bit n+1's
                    // low, so after the 40th bit we go straight to CHECK without
                    // waiting for the trailing low to end.
                    w_shift_en   = 1'b1;
                    w_next_state = (r_bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
                end
            end
            S_CHECK: begin
                w_next_state = S_IDLE;
                if (w_sum == r_shift[7:0]) begin
                    w_latch = 1'b1;
                end else begin
                    w_err_ck = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Bit assembly: MSB arrives first, so each new bit enters at the LSB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift   <= 40'd0;
            r_bit_cnt <= 6'd0;
        end else begin
            if (w_clr_bits) begin
                r_bit_cnt <= 6'd0;
            end else if (w_shift_en) begin
                r_shift   <= {r_shift[38:0], w_bit_val};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end
        end
    end

    // Output latch and status. dth_data only changes on a good checksum;
    // err is sticky until the next accepted start clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dth_data    <= 40'd0;
            r_frame_valid <= 1'b0;
            r_err         <= 2'd0;
        end else begin
            r_frame_valid <= w_latch;
            if (w_latch) begin
                r_dth_data <= r_shift;
            end
            if (w_clr_err) begin
                r_err <= 2'd0;
            end else if (w_err_tmo) begin
                r_err <= 2'd1;
            end else if (w_err_ck) begin
                r_err <= 2'd2;
            end
        end
    end

    assign bus.dth_data    = r_dth_data;
    assign bus.frame_valid = r_frame_valid;
    assign bus.err         = r_err;
    assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_dht_frame_reader.sv
// tb_dht_frame_reader
// Bench for dht_frame_reader at CLK_F = 10 MHz (10 cycles per µs) and a 20 µs
// host start pulse. A sensor model answers on the open-drain line; a reference
// model of "the last frame whose checksum is good" is compared against the DUT
// on every clock, and scenario-level literal expectations pin the model.
module tb_dht_frame_reader;

    localparam int unsigned CLK_F      = 10000000;
    localparam int          CYC_PER_US = 10;

    localparam logic [39:0] FRAME_GOOD = 40'h3C001A055B;
    localparam logic [39:0] FRAME_BAD  = 40'h3C001A055C;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic sensorLow = 1'b0;
    wire  dthLine;

    int errors = 0;
    int checks = 0;

    logic [39:0] expData = 40'd0;
    logic [39:0] oldData = 40'd0;
    int windowReq  = 0;
    int windowSeen = 0;
    int windowCnt  = 0;
    int fvSeen     = 0;

    dht_frame_reader_if bus();

    pullup (dthLine);
    assign dthLine = sensorLow ? 1'b0 : 1'bz;

    dht_frame_reader #(
        .CLK_F        (CLK_F),
        .START_LOW_US (20),
        .TIMEOUT_US   (200),
        .BIT_THRESH_US(50),
        .POLL_MS      (2000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .DTH (dthLine),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Hard stop in case something outside the bounded waits stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Every cycle: dth_data must equal the model's last good frame and
    // frame_valid must be low, except in a short window after the final falling
    // edge of a good frame, where the new value and the pulse may appear.
    always @(negedge clk) begin
        if (rst) begin
            if (windowReq != windowSeen) begin
                windowSeen = windowReq;
                windowCnt  = 8;
            end
            if (bus.frame_valid === 1'b1) begin
                fvSeen++;
            end
            checks++;
            if (windowCnt > 0) begin
                windowCnt--;
                if (bus.dth_data !== expData && bus.dth_data !== oldData) begin
                    errors++;
                    $display("[TB] FAIL cycleDataWindow: got 0x%0h, expected 0x%0h or 0x%0h",
                             bus.dth_data, oldData, expData);
                end
            end else if (bus.dth_data !== expData || bus.frame_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL cycleData: got data 0x%0h fv %0b, expected data 0x%0h fv 0",
                         bus.dth_data, bus.frame_valid, expData);
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitUs(input int n);
        waitCycles(n * CYC_PER_US);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d cycles, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic waitLine(input logic level, input int maxCycles, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            if (dthLine === level) begin
                ok = 1'b1;
                break;
            end
            waitCycles(1);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: line never reached %0b within %0d cycles", name, level, maxCycles);
        end
    endtask

    task automatic waitIdle(input int maxCycles, input string name, output int cycles);
        bit ok;
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < maxCycles; i++) begin
            if (bus.busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            waitCycles(1);
            cycles++;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: busy still high after %0d cycles", name, maxCycles);
        end
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        waitCycles(1);
        bus.start = 1'b0;
    endtask

    // Requests a read and plays the sensor side: 80/80 µs response, then nbits
    // data bits (10 µs low, 26 µs high for 0, 70 µs high for 1). A full frame
    // ends with the trailing low that delimits bit 40; a short frame stops right
    // after releasing the line for its last bit, leaving it high. extraStart
    // fires a second start request in the middle of bit 5's low phase.
    task automatic applyStimulus(input logic [39:0] frame, input int nbits, input bit extraStart);
        bit ok;
        int sum;
        bit good;
        pulseStart();
        waitLine(1'b0, 50, "hostStartLow", ok);
        if (!ok) return;
        waitLine(1'b1, 400, "hostRelease", ok);
        if (!ok) return;
        waitUs(10);
        sensorLow = 1'b1;
        waitUs(80);
        sensorLow = 1'b0;
        waitUs(80);
        for (int i = 0; i < nbits; i++) begin
            sensorLow = 1'b1;
            if (extraStart && i == 5) begin
                waitUs(5);
                pulseStart();
                waitUs(5);
            end else begin
                waitUs(10);
            end
            sensorLow = 1'b0;
            if (nbits < 40 && i == nbits - 1) break;
            waitUs(frame[39 - i] ? 70 : 26);
        end
        if (nbits == 40) begin
            sum  = int'(frame[39:32]) + int'(frame[31:24]) + int'(frame[23:16]) + int'(frame[15:8]);
            good = ((sum % 256) == int'(frame[7:0]));
            sensorLow = 1'b1;
            if (good) begin
                oldData = expData;
                expData = frame;
                windowReq++;
            end
            waitUs(10);
            sensorLow = 1'b0;
        end
    endtask

    initial begin
        int cycles;
        int fvBefore;
        bit ok;
        bus.start = 1'b0;

        // Reset state
        rst = 1'b0;
        waitCycles(5);
        checkOutput("resetData", 64'(bus.dth_data), 64'h0);
        checkOutput("resetFv",   64'(bus.frame_valid), 64'h0);
        checkOutput("resetBusy", 64'(bus.busy), 64'h0);
        checkOutput("resetErr",  64'(bus.err), 64'h0);
        checkOutput("resetLine", 64'(dthLine), 64'h1);
        rst = 1'b1;
        waitUs(2);

        // Good frame
        $display("[TB] good frame 0x%0h", FRAME_GOOD);
        fvBefore = fvSeen;
        bus.start = 1'b1;
        waitCycles(1);
        bus.start = 1'b0;
        checkOutput("busyAfterStart", 64'(bus.busy), 64'h1);
        waitCycles(1);
        // Let the sensor task issue its own start; DUT is busy so it is dropped.
        applyStimulus(FRAME_GOOD, 40, 1'b0);
        waitIdle(100, "goodIdle", cycles);
        waitUs(2);
        checkOutput("goodData", 64'(bus.dth_data), 64'h3C001A055B);
        checkOutput("goodErr",  64'(bus.err), 64'h0);
        checkOutput("goodFvCount", 64'(fvSeen - fvBefore), 64'h1);
        checkOutput("goodBusy", 64'(bus.busy), 64'h0);
        waitUs(5);

        // Checksum error
        $display("[TB] checksum error frame 0x%0h", FRAME_BAD);
        fvBefore = fvSeen;
        applyStimulus(FRAME_BAD, 40, 1'b0);
        waitIdle(100, "ckIdle", cycles);
        waitUs(2);
        checkOutput("ckErr",  64'(bus.err), 64'h2);
        checkOutput("ckData", 64'(bus.dth_data), 64'h3C001A055B);
        checkOutput("ckFvCount", 64'(fvSeen - fvBefore), 64'h0);
        waitUs(5);

        // No response after release
        $display("[TB] silent sensor timeout");
        fvBefore = fvSeen;
        pulseStart();
        checkOutput("tmoErrCleared", 64'(bus.err), 64'h0);
        waitLine(1'b0, 50, "tmoStartLow", ok);
        waitLine(1'b1, 400, "tmoRelease", ok);
        waitIdle(3000, "tmoIdle", cycles);
        checkRange("tmoDelay", cycles, 1985, 2015);
        checkOutput("tmoErr", 64'(bus.err), 64'h1);
        checkOutput("tmoFvCount", 64'(fvSeen - fvBefore), 64'h0);
        waitUs(5);

        // Sensor stalls high during bit 17
        $display("[TB] mid-bit timeout after 17 bits");
        fvBefore = fvSeen;
        applyStimulus(FRAME_GOOD, 17, 1'b0);
        waitIdle(3000, "midIdle", cycles);
        checkRange("midDelay", cycles, 1985, 2015);
        checkOutput("midErr", 64'(bus.err), 64'h1);
        checkOutput("midFvCount", 64'(fvSeen - fvBefore), 64'h0);
        waitUs(5);

        // Recovery read with a start pulse injected during BIT_LOW
        $display("[TB] recovery read with start while busy");
        fvBefore = fvSeen;
        applyStimulus(FRAME_GOOD, 40, 1'b1);
        waitIdle(100, "recIdle", cycles);
        waitUs(2);
        checkOutput("recData", 64'(bus.dth_data), 64'h3C001A055B);
        checkOutput("recErr",  64'(bus.err), 64'h0);
        checkOutput("recFvCount", 64'(fvSeen - fvBefore), 64'h1);
        checkOutput("recBusy", 64'(bus.busy), 64'h0);
        waitUs(5);

        // Reset in the middle of the host start pulse
        $display("[TB] reset during start pulse");
        pulseStart();
        waitLine(1'b0, 50, "rstStartLow", ok);
        waitUs(5);
        rst     = 1'b0;
        expData = 40'd0;
        oldData = 40'd0;
        #1;
        checkOutput("midRstLine", 64'(dthLine), 64'h1);
        checkOutput("midRstBusy", 64'(bus.busy), 64'h0);
        checkOutput("midRstErr",  64'(bus.err), 64'h0);
        checkOutput("midRstData", 64'(bus.dth_data), 64'h0);
        waitCycles(3);
        rst = 1'b1;
        waitUs(3);
        checkOutput("postRstBusy", 64'(bus.busy), 64'h0);
        checkOutput("postRstLine", 64'(dthLine), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dht_frame_reader.md
Name: dht_frame_reader

Overview:
- Single-wire DHT11/DHT22 protocol master. Sits directly upstream of the dynamic-indicator stage and produces the 40-bit frame it consumes on dth_data.
- Issues the start pulse on the bidirectional DTH line and times the sensor response and 40 data bits.
- Checks the checksum and latches good frames.
- Reports busy, frame-valid and error status.

Parameters:
- CLK_F, 100000000, system clock frequency in Hz; microsecond tick divider = CLK_F/1000000.
- START_LOW_US, 18000, host start pulse low time in µs.
- TIMEOUT_US, 200, maximum time any single line level may persist after the start pulse before aborting.
- BIT_THRESH_US, 50, data-bit high time above which the bit is 1 (strictly greater).
- POLL_MS, 2000, auto-poll period in ms (used only with DHT_AUTO_POLL_EN).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to read a frame; ignored while busy
- DTH  inout  1  open-drain sensor line; driven 0 or released to Z, never driven 1
- dth_data  output  40  last good frame {RH_int, RH_dec, T_int, T_dec, checksum}, MSB first
- frame_valid  output  1  one-cycle pulse when dth_data is updated
- busy  output  1  high from accepted start until return to IDLE
- err  output  2  0 none, 1 timeout, 2 checksum; sticky until the next accepted start

Behaviour:
- Clock/reset: one clock (clk). Reset is asynchronous, active-low (rst=0).
- Reset state: dth_data=0, frame_valid=0, busy=0, err=0, DTH released, FSM=IDLE, all counters 0.
- Reset mid-frame: DTH is released immediately; nothing is latched.
- Input sampling: DTH is sampled through a 2-flop synchronizer; all edge decisions use the synchronized value. Edge detection adds 2-3 cycles of latency, which is negligible against µs timing.
- Tick generator: free-running prescaler pulses us_tick every CLK_F/1000000 cycles. The µs counter increments on us_tick and is cleared on every state change.
- FSM states and transitions:
  - IDLE: start=1 → START_LOW; busy=1; err=0.
  - START_LOW: drive DTH=0. When the µs counter reaches START_LOW_US → RELEASE.
  - RELEASE: DTH released. Synced DTH falls → RESP_LOW.
  - RESP_LOW: sensor ~80µs low. Rising edge → RESP_HIGH.
  - RESP_HIGH: sensor ~80µs high. Falling edge → BIT_LOW; bit_cnt=0.
  - BIT_LOW: ~50µs low. Rising edge → BIT_HIGH.
  - BIT_HIGH: falling edge → shift (µs counter > BIT_THRESH_US) into shift[39:0] at the LSB; bit_cnt++. If bit_cnt reaches 40 → CHECK, else → BIT_LOW.
  - CHECK: sum = shift[39:32]+shift[31:24]+shift[23:16]+shift[15:8], truncated to 8 bits.
    - sum==shift[7:0]: dth_data<=shift; frame_valid=1 for one cycle; → IDLE.
    - Otherwise: err=2; dth_data unchanged; → IDLE.
  - Timeout: in RELEASE through BIT_HIGH, a µs counter ≥ TIMEOUT_US → err=1; DTH released; → IDLE. The counter is cleared on each state change, so the limit applies per level.
- busy falls in the cycle the FSM enters IDLE.
- start asserted while busy is dropped and not queued.
- start coinciding with the return to IDLE is ignored; start is sampled only in IDLE.
- The last bit's trailing ~50µs low is not awaited; the line returns to pull-up on its own.
- Sensor frames arriving without a start are ignored: IDLE does not watch DTH.
- Latency: frame_valid asserts 2-4 clk after the 40th falling edge on the DTH pin.

Optional Feature:
- Macro: DHT_AUTO_POLL_EN.
- Defined:
  - A ms-prescaled counter issues an internal start every POLL_MS.
  - The first internal start fires POLL_MS after reset release.
  - The internal start is ORed with the start port; if busy when it fires, it is dropped and the period counter restarts.
- Undefined: reads occur only on the start port; the poll counter is not instantiated.

Test Plan:
- Simulation parameters for all scenarios: CLK_F=10000000, START_LOW_US=20.
- Reset: assert rst=0 mid-START_LOW → DTH goes to Z within the same cycle; dth_data=0, busy=0, err=0.
- Good frame: pulse start; the sensor model replies 80/80µs, then frame 0x3C00_1A05_5B with 0-bits 26µs high and 1-bits 70µs high → DTH low for 20µs; frame_valid single pulse; dth_data=40'h3C001A055B; err=0.
- Checksum error: same as the good frame but checksum byte 0x5C → no frame_valid; err=2; dth_data keeps its previous value.
- Timeout: the sensor never pulls low after release → busy drops 200µs after release with err=1; no frame_valid.
- Mid-bit timeout: the sensor stops after 17 bits, holding the line high → err=1 at 200µs; a following start reads the good frame successfully.
- Start while busy: a second start pulse during BIT_LOW → ignored; exactly one frame_valid. With DHT_AUTO_POLL_EN and POLL_MS=1: an internal read occurs every 1 ms without the start port.
